seg_scan_controller: RTL

- Time-multiplexes a 4-digit common-anode 7-segment display.
- Accepts a 4-digit BCD result plus a sign flag over a valid/ready handshake and double-buffers it.
- Cycles one digit at a time into the shared BCD-to-cathode decoder and drives the active-low anodes.
- Sits between the calculator result path and the cathode decoder; applies leading-zero blanking, minus-sign placement and inter-digit ghost blanking.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/scan_prescaler.sv | 29 ++
 rtl/seg_scan_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants, payload type and helpers for the 7-segment scan controller.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
    localparam logic [3:0]  MINUS_CODE = 4'd15;
    localparam logic [3:0]  ANODES_OFF = 4'b1111;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic             neg;
        logic [BCD_W-1:0] bcd;
    } seg_val_t;

    // Highest digit index holding a nonzero nibble; 0 when the value is all zeros.
    function automatic logic [1:0] find_msd(input logic [BCD_W-1:0] v);
        logic [1:0] m;
        m = 2'd0;
        for (int i = 1; i < int'(NUM_DIGITS); i++) begin
            if (v[i*4 +: 4] != 4'd0) begin
                m = 2'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot timebase: counts REFRESH_DIV cycles per slot and flags the blanking window.
module scan_prescaler #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_tick,
    output logic in_blank
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;

    assign slot_tick = (cnt == CW'(REFRESH_DIV - 1));
    assign in_blank  = (cnt < CW'(BLANK_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (slot_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Double-buffered 4-digit multiplexed display driver with leading-zero blanking,
// minus-sign placement and inter-digit ghost blanking.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BCD_W-1:0] in_bcd,
    input  logic             in_neg,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       digit,
    output logic [3:0]       an,
    output logic             ovf
);

    logic        slot_tick;
    logic        in_blank;
    logic [1:0]  idx;
    seg_val_t    disp;
    seg_val_t    pend;
    logic        pend_valid;
    scan_state_e state;
    scan_state_e state_next;
    logic [3:0]  an_next;
    logic [3:0]  digit_next;
    logic [1:0]  msd;
    logic [3:0]  nibble;
    logic        frame_wrap;
    logic        xfer;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_tick(slot_tick),
        .in_blank (in_blank)
    );

    assign frame_wrap = slot_tick && (idx == 2'd3);
    assign xfer       = in_valid && in_ready;

    // Digit index, pending buffer and frame-boundary commit; pending is non-empty exactly while in_ready is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            in_ready   <= 1'b1;
            ovf        <= 1'b0;
        end else begin
            if (slot_tick) begin
                idx <= idx + 2'd1;
            end
            if (frame_wrap && pend_valid) begin
                disp <= pend;
                ovf  <= pend.neg && (find_msd(pend.bcd) == 2'd3);
            end
            if (xfer) begin
                pend       <= '{neg: in_neg, bcd: in_bcd};
                pend_valid <= 1'b1;
                in_ready   <= 1'b0;
            end else if (frame_wrap) begin
                pend_valid <= 1'b0;
                in_ready   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_BLANK;
            an    <= ANODES_OFF;
            digit <= 4'd0;
        end else begin
            state <= state_next;
            an    <= an_next;
            digit <= digit_next;
        end
    end

    assign msd    = find_msd(disp.bcd);
    assign nibble = disp.bcd[{idx, 2'b00} +: 4];

    // Slot phase and lit/code decision for the current digit.
    always_comb begin
        state_next = in_blank ? S_BLANK : S_ON;
        an_next    = ANODES_OFF;
        digit_next = 4'd0;
        case (state_next)
            S_ON: begin
                if (idx <= msd) begin
                    an_next[idx] = 1'b0;
                    digit_next   = nibble;
                end else if (disp.neg && (msd != 2'd3) && (idx == msd + 2'd1)) begin
                    an_next[idx] = 1'b0;
                    digit_next   = MINUS_CODE;
                end
            end
            default: begin
                an_next    = ANODES_OFF;
                digit_next = 4'd0;
            end
        endcase
    end

endmodule
